// File: rtl/lw_sha_regif_pkg.sv
// ---------------------------------------------------------------------------
// lw_sha_regif_pkg : address map, register bit indices and packer helper
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package lw_sha_regif_pkg;

  localparam logic [11:0] c_addr_id      = 12'h000;
  localparam logic [11:0] c_addr_cfg     = 12'h010;
  localparam logic [11:0] c_addr_ctl     = 12'h020;
  localparam logic [11:0] c_addr_sts     = 12'h030;
  localparam logic [11:0] c_addr_ie      = 12'h040;
  localparam logic [11:0] c_addr_hash_lo = 12'h100;
  localparam logic [11:0] c_addr_din     = 12'h140;
  localparam logic [11:0] c_addr_key     = 12'h150;

  localparam int c_cfg_srst   = 31;
  localparam int c_cfg_wide_a = 1;
  localparam int c_cfg_wide_b = 2;

  localparam int c_ctl_start = 0;
  localparam int c_ctl_last  = 1;
  localparam int c_ctl_abort = 2;

  localparam int c_sts_done     = 0;
  localparam int c_sts_ready    = 1;
  localparam int c_sts_ovf      = 2;
  localparam int c_sts_core_rdy = 3;
  localparam int c_sts_fault    = 4;
  localparam int c_sts_empty    = 5;

  localparam logic [4:0] c_irq_mask = 5'b10101;

  typedef struct packed {
    logic fault;
    logic ovf;
    logic done;
  } sts_sticky_t;

  function automatic int unsigned beats_per_word(input int unsigned bus_dw,
                                                 input int unsigned word_size,
                                                 input logic        wide_req);
    return (word_size == 64 && bus_dw == 32 && wide_req) ? 2 : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lw_sha_regif_fifo_if.sv
// ---------------------------------------------------------------------------
// lw_sha_regif_fifo_if : bus-side register port plus data/key streams to core
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface lw_sha_regif_fifo_if #(
  parameter int BUS_DW    = 32,
  parameter int WORD_SIZE = 64
) ();

  logic                 wr_i;
  logic [11:0]          waddr_i;
  logic [BUS_DW-1:0]    wdata_i;
  logic                 wr_ack_o;
  logic                 rd_i;
  logic [11:0]          raddr_i;
  logic [BUS_DW-1:0]    rdata_o;
  logic                 read_valid_o;
  logic                 slv_error_o;

  logic [WORD_SIZE-1:0] data_o;
  logic                 valid_o;
  logic                 ready_i;
  logic [WORD_SIZE-1:0] key_o;
  logic                 key_valid_o;
  logic                 key_ready_i;

  modport slave (
    input  wr_i, waddr_i, wdata_i, rd_i, raddr_i, ready_i, key_ready_i,
    output wr_ack_o, rdata_o, read_valid_o, slv_error_o,
           data_o, valid_o, key_o, key_valid_o
  );

  modport master (
    output wr_i, waddr_i, wdata_i, rd_i, raddr_i, ready_i, key_ready_i,
    input  wr_ack_o, rdata_o, read_valid_o, slv_error_o,
           data_o, valid_o, key_o, key_valid_o
  );

endinterface

`default_nettype wire

// File: rtl/lw_sha_word_fifo.sv
// ---------------------------------------------------------------------------
// lw_sha_word_fifo : power-of-2 word FIFO with level count and sync flush
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lw_sha_word_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                    clk_i,
  input  logic                    resetn_i,
  input  logic                    flush_i,
  input  logic                    push_i,
  input  logic [WIDTH-1:0]        data_i,
  output logic                    full_o,
  input  logic                    pop_i,
  output logic [WIDTH-1:0]        data_o,
  output logic                    empty_o,
  output logic [$clog2(DEPTH):0]  level_o
);

  localparam int c_aw = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]  r_wr_ptr;
  logic [c_aw-1:0]  r_rd_ptr;
  logic [c_aw:0]    r_level;

  logic w_pop;
  logic w_push;

  assign empty_o = (r_level == '0);
  assign full_o  = (r_level == (c_aw + 1)'(DEPTH));
  assign w_pop   = pop_i & ~empty_o;
  // A push at full is taken only when the same cycle frees a slot.
  assign w_push  = push_i & (~full_o | w_pop);
  assign level_o = r_level;
  assign data_o  = empty_o ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push && !flush_i) r_mem[r_wr_ptr] <= data_i;
  end

endmodule

`default_nettype wire

// File: rtl/lw_sha_regif_fifo.sv
// ---------------------------------------------------------------------------
// lw_sha_regif_fifo : bus register interface, DIN/KEY packers and data FIFO
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lw_sha_regif_fifo
  import lw_sha_regif_pkg::*;
#(
  parameter int          BUS_DW     = 32,
  parameter int          WORD_SIZE  = 64,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] ID_VAL     = 32'h0
) (
  input  logic                     clk_i,
  input  logic                     resetn_i,
  lw_sha_regif_fifo_if.slave       bus,
  input  logic [8*WORD_SIZE-1:0]   hash_i,
  input  logic                     done_i,
  input  logic                     core_ready_i,
  input  logic                     fault_inj_det_i,
  output logic                     start_o,
  output logic                     abort_o,
  output logic                     last_o,
  output logic [3:0]               opcode_o,
  output logic                     core_reset_o,
  output logic                     irq_o
);

  localparam int c_lvl_w      = $clog2(FIFO_DEPTH) + 1;
  localparam int c_idx_lsb    = $clog2(BUS_DW / 8);
  localparam int c_idx_w      = 6 - c_idx_lsb;
  localparam int c_hash_words = (8 * WORD_SIZE) / BUS_DW;
  localparam int c_hi_shift   = WORD_SIZE - BUS_DW;

  logic                 r_srst;
  logic [4:0]           r_cfg_mid;
  logic [3:0]           r_cfg_op;
  logic                 r_start_pend;
  logic                 r_last;
  logic                 r_abort;
  logic [2:0]           r_ie;
  sts_sticky_t          r_sticky;
  logic                 r_din_phase;
  logic                 r_key_phase;
  logic [WORD_SIZE-1:0] r_din_hi;
  logic [WORD_SIZE-1:0] r_key_hi;
  logic [WORD_SIZE-1:0] r_key;
  logic                 r_key_valid;
  logic [BUS_DW-1:0]    r_rdata;
  logic                 r_rvalid;
  logic                 r_slverr;
  logic                 r_irq;

  logic                 w_wr_ok, w_wr_cfg, w_wr_ctl, w_wr_sts, w_wr_ie, w_wr_din, w_wr_key;
  logic                 w_abort, w_flush, w_wide;
  logic [WORD_SIZE-1:0] w_beat_word, w_hi_word, w_fifo_wdata, w_key_word;
  logic                 w_fifo_full, w_fifo_empty, w_fifo_pop, w_fifo_push;
  logic [c_lvl_w-1:0]   w_fifo_level;
  logic                 w_din_take, w_din_ovf, w_key_take, w_key_ovf;
  sts_sticky_t          w_sticky_nxt;
  logic [31:0]          w_sts, w_reg32;
  logic [4:0]           w_irq_src, w_ie5;
  logic [c_idx_w-1:0]   w_hash_idx;
  logic [BUS_DW-1:0]    w_hash_sel, w_rd_val;
  logic                 w_rd_err;

  // Bus writes landing in the soft-reset cycle are dropped.
  assign w_wr_ok  = bus.wr_i & ~r_srst;
  assign w_wr_cfg = w_wr_ok & (bus.waddr_i == c_addr_cfg);
  assign w_wr_ctl = w_wr_ok & (bus.waddr_i == c_addr_ctl);
  assign w_wr_sts = w_wr_ok & (bus.waddr_i == c_addr_sts);
  assign w_wr_ie  = w_wr_ok & (bus.waddr_i == c_addr_ie);
  assign w_wr_din = w_wr_ok & (bus.waddr_i == c_addr_din);
  assign w_wr_key = w_wr_ok & (bus.waddr_i == c_addr_key);

  assign w_abort = w_wr_ctl & bus.wdata_i[c_ctl_abort];
  assign w_flush = r_srst | w_abort;
  assign w_wide  = (beats_per_word(BUS_DW, WORD_SIZE,
                                   r_cfg_op[c_cfg_wide_a] | r_cfg_op[c_cfg_wide_b]) == 2);

  assign w_beat_word = WORD_SIZE'(bus.wdata_i);
  assign w_hi_word   = w_beat_word << c_hi_shift;

  assign w_fifo_pop   = bus.ready_i & ~w_fifo_empty;
  assign w_din_take   = w_wr_din & (~w_fifo_full | w_fifo_pop);
  assign w_din_ovf    = w_wr_din & w_fifo_full & ~w_fifo_pop;
  assign w_fifo_push  = w_din_take & (~w_wide | r_din_phase);
  assign w_fifo_wdata = w_wide ? (r_din_hi | w_beat_word) : w_beat_word;

  assign w_key_take = w_wr_key & (~r_key_valid | bus.key_ready_i);
  assign w_key_ovf  = w_wr_key & r_key_valid & ~bus.key_ready_i;
  assign w_key_word = w_wide ? (r_key_hi | w_beat_word) : w_beat_word;

  lw_sha_word_fifo #(
    .WIDTH (WORD_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i    (clk_i),
    .resetn_i (resetn_i),
    .flush_i  (w_flush),
    .push_i   (w_fifo_push),
    .data_i   (w_fifo_wdata),
    .full_o   (w_fifo_full),
    .pop_i    (bus.ready_i),
    .data_o   (bus.data_o),
    .empty_o  (w_fifo_empty),
    .level_o  (w_fifo_level)
  );

  // Explicit set events override a same-cycle write-1-to-clear.
  always_comb begin
    w_sticky_nxt = r_sticky;
    if (w_wr_sts) begin
      if (bus.wdata_i[c_sts_done])  w_sticky_nxt.done  = 1'b0;
      if (bus.wdata_i[c_sts_ovf])   w_sticky_nxt.ovf   = 1'b0;
      if (bus.wdata_i[c_sts_fault]) w_sticky_nxt.fault = 1'b0;
    end
    if (done_i)                 w_sticky_nxt.done  = 1'b1;
    if (w_din_ovf | w_key_ovf)  w_sticky_nxt.ovf   = 1'b1;
    if (fault_inj_det_i)        w_sticky_nxt.fault = 1'b1;
  end

  assign w_sts = {16'h0, 8'(w_fifo_level), 2'b00, w_fifo_empty, r_sticky.fault,
                  core_ready_i, r_sticky.ovf, ~w_fifo_full, r_sticky.done};
  assign w_irq_src = {r_sticky.fault, 1'b0, r_sticky.ovf, 1'b0, r_sticky.done};
  assign w_ie5     = {r_ie[2], 1'b0, r_ie[1], 1'b0, r_ie[0]};

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_srst       <= 1'b0;
      r_cfg_mid    <= '0;
      r_cfg_op     <= '0;
      r_start_pend <= 1'b0;
      r_last       <= 1'b0;
      r_abort      <= 1'b0;
      r_ie         <= '0;
      r_sticky     <= '0;
      r_irq        <= 1'b0;
      r_din_phase  <= 1'b0;
      r_key_phase  <= 1'b0;
      r_din_hi     <= '0;
      r_key_hi     <= '0;
      r_key        <= '0;
      r_key_valid  <= 1'b0;
    end else if (r_srst) begin
      r_srst       <= 1'b0;
      r_cfg_mid    <= '0;
      r_cfg_op     <= '0;
      r_start_pend <= 1'b0;
      r_last       <= 1'b0;
      r_abort      <= 1'b0;
      r_ie         <= '0;
      r_sticky     <= '0;
      r_irq        <= 1'b0;
      r_din_phase  <= 1'b0;
      r_key_phase  <= 1'b0;
      r_key        <= '0;
      r_key_valid  <= 1'b0;
    end else begin
      if (w_wr_cfg) begin
        r_srst    <= bus.wdata_i[c_cfg_srst];
        r_cfg_mid <= bus.wdata_i[12:8];
        r_cfg_op  <= bus.wdata_i[3:0];
      end
      if (w_wr_ie)
        r_ie <= {bus.wdata_i[c_sts_fault], bus.wdata_i[c_sts_ovf], bus.wdata_i[c_sts_done]};
      r_sticky <= w_sticky_nxt;
      r_irq    <= |(w_irq_src & w_ie5 & c_irq_mask);
      r_abort  <= w_abort;

      if (w_abort) begin
        r_start_pend <= 1'b0;
        r_last       <= 1'b0;
        r_din_phase  <= 1'b0;
        r_key_phase  <= 1'b0;
        r_key_valid  <= 1'b0;
      end else begin
        if (w_wr_ctl && bus.wdata_i[c_ctl_start]) r_start_pend <= 1'b1;
        else if (start_o)                          r_start_pend <= 1'b0;

        if (w_wr_ctl && bus.wdata_i[c_ctl_last]) r_last <= 1'b1;
        else if (done_i)                          r_last <= 1'b0;

        if (w_din_take) begin
          if (w_wide && !r_din_phase) begin
            r_din_hi    <= w_hi_word;
            r_din_phase <= 1'b1;
          end else begin
            r_din_phase <= 1'b0;
          end
        end

        if (r_key_valid && bus.key_ready_i) r_key_valid <= 1'b0;
        if (w_key_take) begin
          if (w_wide && !r_key_phase) begin
            r_key_hi    <= w_hi_word;
            r_key_phase <= 1'b1;
          end else begin
            r_key       <= w_key_word;
            r_key_valid <= 1'b1;
            r_key_phase <= 1'b0;
          end
        end
      end
    end
  end

  assign w_hash_idx = bus.raddr_i[5:c_idx_lsb];

  always_comb begin
    w_hash_sel = '0;
    for (int i = 0; i < c_hash_words; i++) begin
      if (w_hash_idx == c_idx_w'(i)) w_hash_sel = hash_i[i*BUS_DW +: BUS_DW];
    end
  end

  always_comb begin
    w_reg32  = 32'h0;
    w_rd_err = 1'b0;
    w_rd_val = '0;
    if (bus.raddr_i[11:6] == c_addr_hash_lo[11:6]) begin
      w_rd_val = w_hash_sel;
    end else begin
      case (bus.raddr_i)
        c_addr_id:  w_reg32 = ID_VAL;
        c_addr_cfg: w_reg32 = {r_srst, 18'h0, r_cfg_mid, 4'h0, r_cfg_op};
        c_addr_ctl: w_reg32 = {29'h0, r_abort, r_last, r_start_pend};
        c_addr_sts: w_reg32 = w_sts;
        c_addr_ie:  w_reg32 = {27'h0, w_ie5};
        c_addr_din, c_addr_key: w_reg32 = 32'h0;
        default:    w_rd_err = 1'b1;
      endcase
      w_rd_val = BUS_DW'(w_reg32);
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_slverr <= 1'b0;
    end else begin
      r_rvalid <= bus.rd_i;
      r_slverr <= bus.rd_i & w_rd_err;
      if (bus.rd_i) r_rdata <= w_rd_val;
    end
  end

  assign bus.wr_ack_o     = ~w_fifo_full;
  assign bus.valid_o      = ~w_fifo_empty;
  assign bus.key_o        = r_key;
  assign bus.key_valid_o  = r_key_valid;
  assign bus.rdata_o      = r_rdata;
  assign bus.read_valid_o = r_rvalid;
  assign bus.slv_error_o  = r_slverr;

  assign start_o      = r_start_pend & core_ready_i & ~r_srst;
  assign abort_o      = r_abort;
  assign last_o       = r_last;
  assign opcode_o     = r_cfg_op;
  assign core_reset_o = ~r_srst;
  assign irq_o        = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_lw_sha_regif_fifo.sv
// ---------------------------------------------------------------------------
// tb_lw_sha_regif_fifo : directed stimulus with read/data scoreboards
// Revision: 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_lw_sha_regif_fifo;
  import lw_sha_regif_pkg::*;

  localparam int          BUS_DW     = 32;
  localparam int          WORD_SIZE  = 64;
  localparam int          FIFO_DEPTH = 4;
  localparam logic [31:0] ID_VAL     = 32'h5AA5_0001;

  logic                   clk = 1'b0;
  logic                   resetn = 1'b0;
  logic [8*WORD_SIZE-1:0] hash;
  logic                   done = 1'b0, core_ready = 1'b0, fault = 1'b0;
  logic                   start, abort_s, last, core_reset, irq;
  logic [3:0]             opcode;

  lw_sha_regif_fifo_if #(.BUS_DW(BUS_DW), .WORD_SIZE(WORD_SIZE)) bus ();

  lw_sha_regif_fifo #(
    .BUS_DW(BUS_DW), .WORD_SIZE(WORD_SIZE), .FIFO_DEPTH(FIFO_DEPTH), .ID_VAL(ID_VAL)
  ) dut (
    .clk_i(clk), .resetn_i(resetn), .bus(bus), .hash_i(hash),
    .done_i(done), .core_ready_i(core_ready), .fault_inj_det_i(fault),
    .start_o(start), .abort_o(abort_s), .last_o(last), .opcode_o(opcode),
    .core_reset_o(core_reset), .irq_o(irq)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] data; logic err; } rd_exp_t;

  int          total = 0, bad = 0;
  int          cyc = 0, start_cnt = 0, start_cyc = -1, raise_cyc;
  rd_exp_t     rd_q[$];
  logic [63:0] dat_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: compares every read response and every FIFO pop against the queues.
  always @(negedge clk) begin
    rd_exp_t     e;
    logic [63:0] d;
    if (resetn) begin
      if (start) begin
        start_cnt++;
        start_cyc = cyc;
      end
      if (bus.read_valid_o) begin
        if (rd_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_read: got %h want none", bus.rdata_o);
        end else begin
          e = rd_q.pop_front();
          check("read", {31'h0, bus.slv_error_o, bus.rdata_o}, {31'h0, e.err, e.data});
        end
      end
      if (bus.valid_o && bus.ready_i) begin
        if (dat_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_pop: got %h want none", bus.data_o);
        end else begin
          d = dat_q.pop_front();
          check("fifo_pop", bus.data_o, d);
        end
      end
    end
  end

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    bus.wr_i = 1'b1; bus.waddr_i = a; bus.wdata_i = d;
    @(posedge clk); #1;
    bus.wr_i = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] d, input logic err);
    rd_q.push_back({d, err});
    bus.rd_i = 1'b1; bus.raddr_i = a;
    @(posedge clk); #1;
    bus.rd_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) hash[i*32 +: 32] = 32'hC0DE_0000 + i;
    bus.wr_i = 0; bus.waddr_i = '0; bus.wdata_i = '0;
    bus.rd_i = 0; bus.raddr_i = '0; bus.ready_i = 0; bus.key_ready_i = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {55'h0, core_reset, bus.valid_o, start, abort_s, last, irq,
                            bus.key_valid_o, bus.read_valid_o, bus.slv_error_o},
          {55'h0, 9'b1_0000_0000});
    check("reset_data_o", bus.data_o, 64'h0);
    @(posedge clk); #1;
    resetn = 1'b1;

    rd(c_addr_id, ID_VAL, 1'b0);
    rd(c_addr_sts, 32'h22, 1'b0);

    // Wide packing: two beats, upper half first
    wr(c_addr_cfg, 32'h2);
    dat_q.push_back(64'hAAAA0001_BBBB0002);
    wr(c_addr_din, 32'hAAAA_0001);
    wr(c_addr_din, 32'hBBBB_0002);
    check("valid_after_pack", {63'h0, bus.valid_o}, 64'h1);
    rd(c_addr_sts, 32'h102, 1'b0);
    bus.ready_i = 1'b1; idle(1); bus.ready_i = 1'b0;
    check("valid_after_pop", {63'h0, bus.valid_o}, 64'h0);

    // Fill to full in narrow mode, overflow, clear OVF, drain
    wr(c_addr_cfg, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      dat_q.push_back(64'(32'h11 * i));
      wr(c_addr_din, 32'h11 * i);
    end
    check("wr_ack_full", {63'h0, bus.wr_ack_o}, 64'h0);
    wr(c_addr_din, 32'h55);
    rd(c_addr_sts, 32'h404, 1'b0);
    wr(c_addr_sts, 32'h4);
    rd(c_addr_sts, 32'h400, 1'b0);
    bus.ready_i = 1'b1; idle(5); bus.ready_i = 1'b0;
    check("drained", {63'h0, bus.valid_o}, 64'h0);
    rd(c_addr_sts, 32'h22, 1'b0);

    // start waits for core_ready
    wr(c_addr_ctl, 32'h1);
    idle(5);
    check("start_held", 64'(start_cnt), 64'd0);
    rd(c_addr_ctl, 32'h1, 1'b0);
    core_ready = 1'b1; raise_cyc = cyc;
    idle(5);
    check("start_once", 64'(start_cnt), 64'd1);
    check("start_cycle", 64'(start_cyc), 64'(raise_cyc));
    core_ready = 1'b0;
    rd(c_addr_ctl, 32'h0, 1'b0);

    // last set by CTL, cleared by done
    wr(c_addr_ctl, 32'h2);
    check("last_set", {63'h0, last}, 64'h1);
    done = 1'b1; idle(1); done = 1'b0;
    check("last_clr", {63'h0, last}, 64'h0);
    rd(c_addr_sts, 32'h23, 1'b0);
    wr(c_addr_sts, 32'h1);
    rd(c_addr_sts, 32'h22, 1'b0);

    // Interrupt and set-wins-over-clear
    wr(c_addr_ie, 32'h1);
    rd(c_addr_ie, 32'h1, 1'b0);
    done = 1'b1; idle(1); done = 1'b0;
    idle(1);
    check("irq_done", {63'h0, irq}, 64'h1);
    done = 1'b1;
    wr(c_addr_sts, 32'h1);
    done = 1'b0;
    rd(c_addr_sts, 32'h23, 1'b0);
    wr(c_addr_sts, 32'h1);
    rd(c_addr_sts, 32'h22, 1'b0);
    check("irq_cleared", {63'h0, irq}, 64'h0);
    fault = 1'b1; idle(1); fault = 1'b0;
    rd(c_addr_sts, 32'h32, 1'b0);
    wr(c_addr_sts, 32'h10);

    // Key packing, hold and overflow
    wr(c_addr_cfg, 32'h2);
    wr(c_addr_key, 32'h1);
    wr(c_addr_key, 32'h2);
    check("key_valid", {63'h0, bus.key_valid_o}, 64'h1);
    check("key_word", bus.key_o, 64'h00000001_00000002);
    wr(c_addr_key, 32'h3);
    rd(c_addr_sts, 32'h26, 1'b0);
    wr(c_addr_sts, 32'h4);
    bus.key_ready_i = 1'b1; idle(1); bus.key_ready_i = 1'b0;
    check("key_taken", {63'h0, bus.key_valid_o}, 64'h0);

    // Abort flushes two queued words, a half word and the key
    for (int i = 1; i <= 5; i++) wr(c_addr_din, 32'(i));
    wr(c_addr_key, 32'h7);
    wr(c_addr_key, 32'h8);
    wr(c_addr_ctl, 32'h4);
    check("abort_state", {61'h0, abort_s, bus.valid_o, bus.key_valid_o}, 64'b100);
    idle(1);
    check("abort_pulse_end", {63'h0, abort_s}, 64'h0);
    rd(c_addr_sts, 32'h22, 1'b0);
    dat_q.push_back(64'h0000000C_0000000D);
    wr(c_addr_din, 32'hC);
    wr(c_addr_din, 32'hD);
    bus.ready_i = 1'b1; idle(1); bus.ready_i = 1'b0;

    // Soft reset
    wr(c_addr_ie, 32'h15);
    rd(c_addr_ie, 32'h15, 1'b0);
    wr(c_addr_cfg, 32'h8000_0003);
    check("core_reset_low", {63'h0, core_reset}, 64'h0);
    idle(1);
    check("core_reset_high", {63'h0, core_reset}, 64'h1);
    rd(c_addr_cfg, 32'h0, 1'b0);
    rd(c_addr_ie, 32'h0, 1'b0);
    check("opcode_cleared", {60'h0, opcode}, 64'h0);

    // HASH window and unmapped access
    rd(12'h104, 32'hC0DE_0001, 1'b0);
    rd(12'h13C, 32'hC0DE_000F, 1'b0);
    rd(12'h200, 32'h0, 1'b1);
    rd(c_addr_din, 32'h0, 1'b0);

    idle(3);
    check("rd_q_drained", 64'(rd_q.size()), 64'd0);
    check("dat_q_drained", 64'(dat_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
